// File: rtl/mux_arb_2x1_pkg.sv
// Shared select encoding for the 2:1 arbiter and downstream consumers of out_sel.
// Optional burst locking is enabled with MUX_ARB_BURST_EN (see mux_arb_2x1).
package mux_arb_pkg;

  typedef logic sel_t;

  localparam sel_t SEL_A = 1'b0;
  localparam sel_t SEL_B = 1'b1;

  // Round-robin pick: a tie goes to whichever source did not win last time.
  function automatic sel_t rr_pick(input logic a_vld, input logic b_vld, input sel_t last_sel);
    if (a_vld && b_vld) return sel_t'(~last_sel);
    else if (b_vld)     return SEL_B;
    else                return SEL_A;
  endfunction

endpackage

// File: rtl/mux_arb_2x1_if.sv
// Handshake bundle between two producers, the arbiter and one consumer.
// Last-beat signals exist only when MUX_ARB_BURST_EN is defined.
interface mux_arb_2x1_if #(parameter int W = 8);
  import mux_arb_pkg::*;

  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  sel_t         out_sel;
  logic         out_ready;
`ifdef MUX_ARB_BURST_EN
  logic         a_last;
  logic         b_last;
  logic         out_last;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel, out_last
  );
  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/mux_arb_2x1_mux.sv
// One-bit 2:1 mux slice of the arbiter payload datapath; sel=0 picks a_i.
module mux_2x1
  import mux_arb_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  sel_t sel_i,
  output logic y_o
);

  assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule

// File: rtl/mux_arb_2x1.sv
// Two-input round-robin arbiter with a single registered output entry; accept at N -> out_valid at N+1.
// MUX_ARB_BURST_EN adds last-beat signals and holds the grant for the length of a burst.
module mux_arb_2x1
  import mux_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mux_arb_2x1_if.slave bus
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  sel_t         out_sel_q,   out_sel_d;
  sel_t         last_sel_q,  last_sel_d;
  logic         load_ok;
  logic         grant_vld;
  sel_t         grant;
  logic         accept;
  logic         lock;
  logic [W-1:0] mux_dat;

`ifdef MUX_ARB_BURST_EN
  logic lock_q,     lock_d;
  logic out_last_q, out_last_d;
  logic beat_last;

  assign lock         = lock_q;
  assign bus.out_last = out_last_q;
  assign beat_last    = (grant == SEL_B) ? bus.b_last : bus.a_last;
`else
  assign lock = 1'b0;
`endif

  // A locked grant only serves its own source; the other input waits.
  always_comb begin
    load_ok = !out_valid_q || bus.out_ready;
    if (lock) begin
      grant     = last_sel_q;
      grant_vld = (last_sel_q == SEL_B) ? bus.b_valid : bus.a_valid;
    end else begin
      grant     = rr_pick(bus.a_valid, bus.b_valid, last_sel_q);
      grant_vld = bus.a_valid || bus.b_valid;
    end
    accept = load_ok && grant_vld;
  end

  assign bus.a_ready = accept && (grant == SEL_A);
  assign bus.b_ready = accept && (grant == SEL_B);

  for (genvar i = 0; i < W; i++) begin : g_mux
    mux_2x1 u_mux (
      .a_i   (bus.a_data[i]),
      .b_i   (bus.b_data[i]),
      .sel_i (grant),
      .y_o   (mux_dat[i])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_sel_d  = last_sel_q;
`ifdef MUX_ARB_BURST_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
      out_sel_d   = grant;
      last_sel_d  = grant;
`ifdef MUX_ARB_BURST_EN
      lock_d      = !beat_last;
      out_last_d  = beat_last;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SEL_A;
      last_sel_q  <= SEL_B;
`ifdef MUX_ARB_BURST_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_sel_q  <= last_sel_d;
`ifdef MUX_ARB_BURST_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Directed plus randomized bench for mux_arb_2x1 with a queue scoreboard of expected output beats.
// Burst-lock steps run only when MUX_ARB_BURST_EN is defined.
module tb_mux_arb_2x1;
  import mux_arb_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] dat;
    logic         sel;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic a_last_tb, b_last_tb;

  always #5 clk = ~clk;

  mux_arb_2x1_if #(.W(W)) bus ();

  mux_arb_2x1 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MUX_ARB_BURST_EN
  assign bus.a_last = a_last_tb;
  assign bus.b_last = b_last_tb;
`endif

  beat_t sb[$];
  logic  m_last_sel;
  logic  m_lock;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the model at negedge, update the model, advance past posedge.
  task automatic cycle();
    logic  ld, gv, g, av, bv, bl;
    beat_t front;
    @(negedge clk);
    av = bus.a_valid;
    bv = bus.b_valid;
    ld = (sb.size() == 0) || bus.out_ready;
    if (m_lock) begin
      g  = m_last_sel;
      gv = g ? bv : av;
    end else begin
      gv = av | bv;
      g  = (av && bv) ? ~m_last_sel : bv;
    end
    if (!rst) begin
      chk("a_ready",    bus.a_ready, ld & gv & ~g);
      chk("b_ready",    bus.b_ready, ld & gv & g);
      chk("rdy_excl",   bus.a_ready & bus.b_ready, 0);
      chk("out_valid",  bus.out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        front = sb[0];
        chk("out_data", bus.out_data, front.dat);
        chk("out_sel",  bus.out_sel,  front.sel);
`ifdef MUX_ARB_BURST_EN
        chk("out_last", bus.out_last, front.last);
`endif
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    if (rst) begin
      sb.delete();
      m_last_sel = 1'b1;
      m_lock     = 1'b0;
    end else if (ld && gv) begin
      bl = g ? b_last_tb : a_last_tb;
      sb.push_back('{dat: (g ? bus.b_data : bus.a_data), sel: g, last: bl});
      m_last_sel = g;
`ifdef MUX_ARB_BURST_EN
      m_lock = !bl;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.out_ready = 1'b0;
    a_last_tb = 1'b1; b_last_tb = 1'b1;
    m_last_sel = 1'b1; m_lock = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    chk("init_valid", bus.out_valid, 0);

    // A alone is granted and appears one cycle later.
    bus.a_valid = 1'b1; bus.a_data = 8'h3C; bus.out_ready = 1'b1;
    cycle();
    bus.a_valid = 1'b0;
    chk("a_only_valid", bus.out_valid, 1);
    chk("a_only_data",  bus.out_data, 8'h3C);
    chk("a_only_sel",   bus.out_sel, 0);
    cycle();

    // Reset while a beat sits in the output register.
    bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.out_ready = 1'b0;
    cycle();
    bus.a_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sel",   bus.out_sel, 0);
    chk("rst_data",  bus.out_data, 0);

    // Both valid: first tie goes to A, then strict alternation.
    bus.a_valid = 1'b1; bus.a_data = 8'hAA;
    bus.b_valid = 1'b1; bus.b_data = 8'h55;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_data", bus.out_data, (k % 2) ? 8'h55 : 8'hAA);
      chk("rr_sel",  bus.out_sel,  k % 2);
    end

    // Backpressure holds the beat; release hands the grant to the other source.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_data", bus.out_data, 8'h55);
      chk("hold_sel",  bus.out_sel, 1);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("release_sel",  bus.out_sel, 0);
    chk("release_data", bus.out_data, 8'hAA);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    cycle(); cycle();

`ifdef MUX_ARB_BURST_EN
    // Three-beat A burst holds off a continuously valid B.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.b_valid = 1'b1; bus.b_data = 8'h5B; b_last_tb = 1'b1;
    bus.a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.a_data = 8'hA0 + 8'(k);
      a_last_tb  = (k == 2);
      cycle();
      chk("burst_sel",  bus.out_sel,  (k == 3));
      chk("burst_last", bus.out_last, (k >= 2));
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    a_last_tb = 1'b1;
    cycle(); cycle();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 200; k++) begin
      bus.a_valid   = 1'($urandom_range(0, 1));
      bus.b_valid   = 1'($urandom_range(0, 1));
      bus.a_data    = 8'($urandom);
      bus.b_data    = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_BURST_EN
      a_last_tb = 1'($urandom_range(0, 1));
      b_last_tb = 1'($urandom_range(0, 1));
`endif
      cycle();
    end

    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.out_ready = 1'b1;
    cycle(); cycle();
    chk("drain_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
